seletor_chamadas_n: RTL and testbench
=====================================

SELETOR_CHAMADAS_N -- requirements
Module: seletor_chamadas_n

Interface
REQ-001 Parameter N_ANDARES, default 3: number of floors served, legal range 2..16.
REQ-002 Parameter AW, default 2: floor index width, SHALL satisfy 2**AW >= N_ANDARES.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 cham_int  input  N_ANDARES  cabin (internal) call buttons, one bit per floor, level.
REQ-006 cham_ext  input  N_ANDARES  hall (external) call buttons, one bit per floor, level.
REQ-007 andar_atual  input  AW  current cabin floor index, 0 = ground.
REQ-008 parado  input  1  cabin stopped at andar_atual with doors open; call at that floor is served.
REQ-009 pend  output  N_ANDARES  registered pending-call vector.
REQ-010 alvo  output  AW  registered target floor index.
REQ-011 alvo_valido  output  1  alvo holds a real target.
REQ-012 sobe  output  1  registered: direction state is SUBINDO.
REQ-013 desce  output  1  registered: direction state is DESCENDO.

Function
REQ-014 Each cycle, next pend[i] SHALL be (pend[i] | cham_int[i] | cham_ext[i]) & ~clr[i].
REQ-015 clr[i] SHALL be 1 only when parado=1 and andar_atual==i; clear wins over simultaneous set on the same floor.
REQ-016 andar_atual >= N_ANDARES SHALL clear nothing; the FSM SHALL then treat no floor as above or below, and the next state SHALL be IDLE.
REQ-017 "Above" = any pend[i]=1 with i > andar_atual; "below" = any pend[i]=1 with i < andar_atual, evaluated on the registered pend.
REQ-018 Direction FSM states: IDLE, SUBINDO, DESCENDO; state register updated every cycle.
REQ-019 IDLE: above -> SUBINDO; else below -> DESCENDO; else stay IDLE; above and below both true -> SUBINDO.
REQ-020 SUBINDO: above -> stay; else below -> DESCENDO; else IDLE.
REQ-021 DESCENDO: below -> stay; else above -> SUBINDO; else IDLE.
REQ-022 alvo/alvo_valido SHALL be registered from the next state: SUBINDO -> lowest pending index above; DESCENDO -> highest pending index below; IDLE with pend[andar_atual]=1 -> andar_atual, valid 1; otherwise alvo=0, alvo_valido=0.
REQ-023 Latency: a call asserted before edge k appears in pend after edge k; sobe/desce/alvo reflect it after edge k+1.
REQ-024 sobe and desce SHALL never be 1 simultaneously; both 0 in IDLE.
REQ-025 Held button while parado at that floor SHALL keep pend bit 0; the bit sets on the first cycle after parado drops if still held.
REQ-026 No combinational path from any input to any output.

Reset
REQ-027 rst=1 at a clock edge SHALL force pend=0, state IDLE, alvo=0, alvo_valido=0, sobe=0, desce=0, overriding all inputs.
REQ-028 Reset asserted mid-travel (SUBINDO/DESCENDO) SHALL discard all pending calls; calls still held after rst deasserts re-latch on the next edge.

Verification
REQ-029 N=3, reset, andar_atual=0, cham_ext=3'b100 one cycle -> pend=100 after 1 edge; sobe=1, alvo=2, alvo_valido=1 after 2 edges.
REQ-030 andar_atual=1, IDLE, cham_int=3'b101 same cycle -> pend=101, SUBINDO, alvo=2 (tie goes up); then andar_atual=2, parado=1 -> pend=001, DESCENDO, alvo=0.
REQ-031 andar_atual=1, parado=1, cham_int=3'b010 held 3 cycles -> pend[1] stays 0; parado drops with button held -> pend=010, IDLE, alvo=1, alvo_valido=1.
REQ-032 SUBINDO toward 2 with pend=101, assert rst one cycle -> all outputs 0, state IDLE; no buttons afterward -> outputs stay 0.
REQ-033 andar_atual=3 (out of range), pend=011, parado=1 -> pend unchanged 011, state IDLE, alvo_valido=0.
REQ-034 N_ANDARES=8, AW=3, andar_atual=4, pend=8'b1000_0010 from IDLE -> SUBINDO alvo=7; serve 7 -> DESCENDO alvo=1; serve 1 -> IDLE, alvo_valido=0.

Source files
------------

// File: rtl/seletor_chamadas_n.sv
// Elevator call selector: latches cabin/hall calls into a pending vector,
// runs an up/down/idle direction FSM over the pending calls and registers
// the next target floor. Every output comes straight from a flop.
module seletor_chamadas_n #(
  parameter int N_ANDARES = 3,
  parameter int AW        = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_ANDARES-1:0] cham_int,
  input  logic [N_ANDARES-1:0] cham_ext,
  input  logic [AW-1:0]        andar_atual,
  input  logic                 parado,
  output logic [N_ANDARES-1:0] pend,
  output logic [AW-1:0]        alvo,
  output logic                 alvo_valido,
  output logic                 sobe,
  output logic                 desce
);

  typedef enum logic [1:0] {IDLE, SUBINDO, DESCENDO} estado_t;

  estado_t               estado;
  estado_t               prox_estado;
  logic                  em_faixa;
  logic [N_ANDARES-1:0]  clr;
  logic [N_ANDARES-1:0]  pend_prox;
  logic                  aqui;
  logic                  acima;
  logic                  abaixo;
  logic [AW-1:0]         menor_acima;
  logic [AW-1:0]         maior_abaixo;
  logic [AW-1:0]         alvo_prox;
  logic                  valido_prox;

  // An out-of-range floor index disables clearing and direction decisions.
  assign em_faixa = (int'(andar_atual) < N_ANDARES);

  // Clear mask for the floor being served; also flags a pending call right here.
  always_comb begin
    clr  = '0;
    aqui = 1'b0;
    for (int i = 0; i < N_ANDARES; i++) begin
      if (parado && em_faixa && (int'(andar_atual) == i)) clr[i] = 1'b1;
      if (pend[i] && em_faixa && (int'(andar_atual) == i)) aqui = 1'b1;
    end
    pend_prox = (pend | cham_int | cham_ext) & ~clr;
  end

  // Pending-call register; clear beats a simultaneous press on the same floor.
  always_ff @(posedge clk) begin
    if (rst) pend <= '0;
    else     pend <= pend_prox;
  end

  // Scan registered pending calls for the nearest one above and below.
  always_comb begin
    acima        = 1'b0;
    abaixo       = 1'b0;
    menor_acima  = '0;
    maior_abaixo = '0;
    for (int i = N_ANDARES - 1; i >= 0; i--) begin
      if (pend[i] && em_faixa && (i > int'(andar_atual))) begin
        acima       = 1'b1;
        menor_acima = AW'(i);
      end
    end
    for (int i = 0; i < N_ANDARES; i++) begin
      if (pend[i] && em_faixa && (i < int'(andar_atual))) begin
        abaixo       = 1'b1;
        maior_abaixo = AW'(i);
      end
    end
  end

  // Direction FSM state register.
  always_ff @(posedge clk) begin
    if (rst) estado <= IDLE;
    else     estado <= prox_estado;
  end

  // Next direction: keep going while calls remain ahead, upward wins ties.
  always_comb begin
    prox_estado = IDLE;
    case (estado)
      IDLE, SUBINDO: begin
        if (acima)       prox_estado = SUBINDO;
        else if (abaixo) prox_estado = DESCENDO;
        else             prox_estado = IDLE;
      end
      DESCENDO: begin
        if (abaixo)      prox_estado = DESCENDO;
        else if (acima)  prox_estado = SUBINDO;
        else             prox_estado = IDLE;
      end
      default:           prox_estado = IDLE;
    endcase
  end

  // Target selection follows the direction the FSM is about to take.
  always_comb begin
    alvo_prox   = '0;
    valido_prox = 1'b0;
    case (prox_estado)
      SUBINDO: begin
        alvo_prox   = menor_acima;
        valido_prox = 1'b1;
      end
      DESCENDO: begin
        alvo_prox   = maior_abaixo;
        valido_prox = 1'b1;
      end
      default: begin
        if (aqui) begin
          alvo_prox   = andar_atual;
          valido_prox = 1'b1;
        end
      end
    endcase
  end

  // Registered target and direction flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      alvo        <= '0;
      alvo_valido <= 1'b0;
      sobe        <= 1'b0;
      desce       <= 1'b0;
    end else begin
      alvo        <= alvo_prox;
      alvo_valido <= valido_prox;
      sobe        <= (prox_estado == SUBINDO);
      desce       <= (prox_estado == DESCENDO);
    end
  end

endmodule

// File: tb/tb_seletor_chamadas_n.sv
// Self-checking bench for seletor_chamadas_n: a 3-floor and an 8-floor
// instance, directed scenarios with literal expectations, then random traffic
// compared every cycle against a behavioural model.
module tb_seletor_chamadas_n;

  logic       clk;
  logic       rst;

  logic [2:0] a_int, a_ext;
  logic [1:0] a_andar;
  logic       a_parado;
  logic [2:0] a_pend;
  logic [1:0] a_alvo;
  logic       a_val, a_sobe, a_desce;

  logic [7:0] b_int, b_ext;
  logic [2:0] b_andar;
  logic       b_parado;
  logic [7:0] b_pend;
  logic [2:0] b_alvo;
  logic       b_val, b_sobe, b_desce;

  int checks;
  int failures;
  bit cmp_en;

  logic [15:0] m_pend_a, m_pend_b;
  int          m_st_a, m_st_b;
  int          m_alvo_a, m_alvo_b;
  bit          m_val_a, m_val_b;

  seletor_chamadas_n #(.N_ANDARES(3), .AW(2)) dut_a (
    .clk(clk), .rst(rst), .cham_int(a_int), .cham_ext(a_ext),
    .andar_atual(a_andar), .parado(a_parado), .pend(a_pend),
    .alvo(a_alvo), .alvo_valido(a_val), .sobe(a_sobe), .desce(a_desce)
  );

  seletor_chamadas_n #(.N_ANDARES(8), .AW(3)) dut_b (
    .clk(clk), .rst(rst), .cham_int(b_int), .cham_ext(b_ext),
    .andar_atual(b_andar), .parado(b_parado), .pend(b_pend),
    .alvo(b_alvo), .alvo_valido(b_val), .sobe(b_sobe), .desce(b_desce)
  );

  // 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural step: 0 = idle, 1 = going up, 2 = going down.
  task automatic model_step(input int n, input logic [15:0] pend_q, input int st,
                            input logic [15:0] ci, input logic [15:0] ce,
                            input int andar, input bit parado_i,
                            output logic [15:0] pend_n, output int st_n,
                            output int alvo_n, output bit val_n);
    int lowest_above;
    int highest_below;
    bit inr;
    inr           = (andar < n);
    lowest_above  = -1;
    highest_below = -1;
    pend_n        = '0;
    for (int i = 0; i < n; i++) begin
      if (pend_q[i] && inr && i > andar && lowest_above < 0) lowest_above = i;
      if (pend_q[i] && inr && i < andar) highest_below = i;
      pend_n[i] = (pend_q[i] | ci[i] | ce[i]) && !(parado_i && inr && andar == i);
    end
    if (st == 2) st_n = (highest_below >= 0) ? 2 : ((lowest_above >= 0) ? 1 : 0);
    else         st_n = (lowest_above >= 0) ? 1 : ((highest_below >= 0) ? 2 : 0);
    alvo_n = 0;
    val_n  = 1'b0;
    if (st_n == 1) begin
      alvo_n = lowest_above;
      val_n  = 1'b1;
    end else if (st_n == 2) begin
      alvo_n = highest_below;
      val_n  = 1'b1;
    end else if (inr && pend_q[andar]) begin
      alvo_n = andar;
      val_n  = 1'b1;
    end
  endtask

  // Reference model advances on the same edge as the DUTs.
  always @(posedge clk) begin
    if (rst) begin
      m_pend_a = '0; m_st_a = 0; m_alvo_a = 0; m_val_a = 1'b0;
      m_pend_b = '0; m_st_b = 0; m_alvo_b = 0; m_val_b = 1'b0;
    end else begin
      model_step(3, m_pend_a, m_st_a, 16'(a_int), 16'(a_ext), int'(a_andar), a_parado,
                 m_pend_a, m_st_a, m_alvo_a, m_val_a);
      model_step(8, m_pend_b, m_st_b, 16'(b_int), 16'(b_ext), int'(b_andar), b_parado,
                 m_pend_b, m_st_b, m_alvo_b, m_val_b);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("model_n3 {pend,alvo,val,sobe,desce}",
                  32'({a_pend, a_alvo, a_val, a_sobe, a_desce}),
                  32'({m_pend_a[2:0], 2'(m_alvo_a), m_val_a, m_st_a == 1, m_st_a == 2}));
      checkOutput("model_n8 {pend,alvo,val,sobe,desce}",
                  32'({b_pend, b_alvo, b_val, b_sobe, b_desce}),
                  32'({m_pend_b[7:0], 3'(m_alvo_b), m_val_b, m_st_b == 1, m_st_b == 2}));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] ci, input logic [2:0] ce,
                               input logic [1:0] andar, input logic par);
    a_int    = ci;
    a_ext    = ce;
    a_andar  = andar;
    a_parado = par;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Directed scenarios with hand-computed values, then random traffic.
  initial begin
    checks   = 0;
    failures = 0;
    cmp_en   = 1'b0;
    rst      = 1'b1;
    applyStimulus(3'b000, 3'b000, 2'd0, 1'b0);
    b_int = '0; b_ext = '0; b_andar = '0; b_parado = 1'b0;
    tick();
    cmp_en = 1'b1;
    tick();
    checkOutput("reset_n3", 32'({a_pend, a_alvo, a_val, a_sobe, a_desce}), 32'h0);
    checkOutput("reset_n8", 32'({b_pend, b_alvo, b_val, b_sobe, b_desce}), 32'h0);
    rst = 1'b0;

    // Hall call at floor 2 from ground.
    applyStimulus(3'b000, 3'b100, 2'd0, 1'b0);
    tick();
    applyStimulus(3'b000, 3'b000, 2'd0, 1'b0);
    checkOutput("r029_pend", 32'(a_pend), 32'h4);
    checkOutput("r029_sobe_early", 32'(a_sobe), 32'h0);
    tick();
    checkOutput("r029_sobe", 32'(a_sobe), 32'h1);
    checkOutput("r029_alvo", 32'(a_alvo), 32'h2);
    checkOutput("r029_val", 32'(a_val), 32'h1);
    pulseReset();

    // Calls above and below at once: upward wins, then serve floor 2.
    applyStimulus(3'b101, 3'b000, 2'd1, 1'b0);
    tick();
    applyStimulus(3'b000, 3'b000, 2'd1, 1'b0);
    checkOutput("r030_pend", 32'(a_pend), 32'h5);
    tick();
    checkOutput("r030_sobe", 32'(a_sobe), 32'h1);
    checkOutput("r030_alvo_up", 32'(a_alvo), 32'h2);
    applyStimulus(3'b000, 3'b000, 2'd2, 1'b1);
    tick();
    checkOutput("r030_pend_served", 32'(a_pend), 32'h1);
    checkOutput("r030_desce", 32'({a_sobe, a_desce}), 32'h1);
    checkOutput("r030_alvo_down", 32'({a_alvo, a_val}), 32'h1);
    applyStimulus(3'b000, 3'b000, 2'd2, 1'b0);
    pulseReset();

    // Reset while climbing drops every call.
    applyStimulus(3'b101, 3'b000, 2'd1, 1'b0);
    tick();
    applyStimulus(3'b000, 3'b000, 2'd1, 1'b0);
    tick();
    checkOutput("r032_sobe_before", 32'(a_sobe), 32'h1);
    pulseReset();
    checkOutput("r032_after_rst", 32'({a_pend, a_alvo, a_val, a_sobe, a_desce}), 32'h0);
    tick();
    tick();
    checkOutput("r032_stays_zero", 32'({a_pend, a_alvo, a_val, a_sobe, a_desce}), 32'h0);

    // Button held while stopped at that floor.
    applyStimulus(3'b010, 3'b000, 2'd1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("r031_held_pend", 32'(a_pend), 32'h0);
    end
    applyStimulus(3'b010, 3'b000, 2'd1, 1'b0);
    tick();
    checkOutput("r031_relatch", 32'(a_pend), 32'h2);
    applyStimulus(3'b000, 3'b000, 2'd1, 1'b0);
    tick();
    checkOutput("r031_idle_target", 32'({a_pend, a_alvo, a_val, a_sobe, a_desce}),
                32'({3'b010, 2'd1, 1'b1, 1'b0, 1'b0}));
    pulseReset();

    // Out-of-range floor index clears nothing and stays idle.
    applyStimulus(3'b011, 3'b000, 2'd3, 1'b0);
    tick();
    applyStimulus(3'b000, 3'b000, 2'd3, 1'b1);
    checkOutput("r033_pend_set", 32'(a_pend), 32'h3);
    tick();
    checkOutput("r033_pend_kept", 32'(a_pend), 32'h3);
    checkOutput("r033_idle", 32'({a_val, a_sobe, a_desce}), 32'h0);
    tick();
    checkOutput("r033_still_idle", 32'({a_pend, a_val, a_sobe, a_desce}), 32'({3'b011, 3'b000}));
    applyStimulus(3'b000, 3'b000, 2'd0, 1'b0);
    pulseReset();

    // Eight floors: up to 7, then down to 1, then idle.
    b_andar = 3'd4; b_int = 8'h82;
    tick();
    b_int = 8'h00;
    checkOutput("r034_pend", 32'(b_pend), 32'h82);
    tick();
    checkOutput("r034_up", 32'({b_sobe, b_desce, b_alvo, b_val}), 32'({2'b10, 3'd7, 1'b1}));
    b_andar = 3'd7; b_parado = 1'b1;
    tick();
    checkOutput("r034_served7", 32'(b_pend), 32'h02);
    checkOutput("r034_down", 32'({b_sobe, b_desce, b_alvo, b_val}), 32'({2'b01, 3'd1, 1'b1}));
    b_parado = 1'b0;
    tick();
    b_andar = 3'd1; b_parado = 1'b1;
    tick();
    tick();
    checkOutput("r034_idle", 32'({b_pend, b_sobe, b_desce, b_val}), 32'h0);
    b_parado = 1'b0;

    // Random traffic with occasional resets and out-of-range floors.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 60) == 0);
      a_int = 3'($urandom) & 3'($urandom) & 3'($urandom);
      a_ext = 3'($urandom) & 3'($urandom) & 3'($urandom);
      if ($urandom_range(0, 3) == 0) a_andar = 2'($urandom);
      a_parado = ($urandom_range(0, 2) == 0);
      b_int = 8'($urandom) & 8'($urandom) & 8'($urandom) & 8'($urandom);
      b_ext = 8'($urandom) & 8'($urandom) & 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 3) == 0) b_andar = 3'($urandom);
      b_parado = ($urandom_range(0, 2) == 0);
      tick();
    end
    rst = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
